// File: rtl/tick_gen_pkg.sv
// Shared constants, types and helpers for the multi-channel tick generator.
package tick_gen_pkg;

    // Half-period counts for common rates from a 50 MHz system clock.
    localparam int unsigned DEFAULT_HALF_50M = 25_000_000;  // 1 Hz
    localparam int unsigned DEFAULT_HALF_1K  = 25_000;      // 1 kHz

    // Width of the counter fields in the debug view of one channel.
    localparam int unsigned STATE_CNT_W = 32;

    // Flattened view of one channel's architectural state.
    typedef struct packed {
        logic [STATE_CNT_W-1:0] cnt;
        logic [STATE_CNT_W-1:0] half_q;
        logic [STATE_CNT_W-1:0] pend_q;
        logic                   pend_v;
        logic                   out_clk;
        logic                   tick;
    } ch_state_t;

    // Channel index width; never below one bit so a single channel still has a select.
    function automatic int unsigned CH_IDX_W(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One programmable clock-enable channel: half-period counter, square-wave toggle,
// rising-edge tick and a one-deep pending config that commits only at a boundary.
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_50M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             out_clk,
    output logic             tick,
    output logic             pend_v
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] eff;
    logic [CNT_W-1:0] last;
    logic             at_term;
    logic             boundary;
    logic             apply;

    // Terminal-count decode; a programmed zero behaves as one so the channel never stalls.
    always_comb begin
        eff      = (half_q == '0) ? CNT_W'(1) : half_q;
        last     = eff - CNT_W'(1);
        at_term  = (cnt_q == last);
        boundary = !en || sync || at_term;
        apply    = pend_v && boundary;
    end

    // Counter and divided-clock phase; disable and sync both park the channel at phase zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (!en || sync) begin
            cnt_q   <= '0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (at_term) begin
            cnt_q   <= '0;
            out_clk <= ~out_clk;
            tick    <= ~out_clk;  // strobe only on the low-to-high toggle
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

    // Pending half-period: captured on a write, committed only at a half-period boundary
    // so an in-flight half-period is never shortened or stretched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q <= CNT_W'(DEFAULT_HALF);
            pend_q <= '0;
            pend_v <= 1'b0;
        end else if (apply) begin
            half_q <= pend_q;
            pend_v <= 1'b0;
        end else if (wr) begin
            pend_q <= wr_half;
            pend_v <= 1'b1;
        end
    end

endmodule

// File: rtl/multi_channel_tick_gen.sv
// NUM_CH independent clock-enable generators sharing one valid/ready config port
// and a global phase-realign pulse.
module multi_channel_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_50M
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic                          sync,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CH_IDX_W(NUM_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]              cfg_half,
    output logic [NUM_CH-1:0]             out_clk,
    output logic [NUM_CH-1:0]             tick
);

    localparam int unsigned CH_W = CH_IDX_W(NUM_CH);

    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] wr;

    // Config decode: ready follows the addressed channel's pending flag; an out-of-range
    // channel reads as ready and its write matches no channel, so it is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend_v[i];
                wr[i]     = cfg_valid && !pend_v[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_gen_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[g]),
            .sync    (sync),
            .wr      (wr[g]),
            .wr_half (cfg_half),
            .out_clk (out_clk[g]),
            .tick    (tick[g]),
            .pend_v  (pend_v[g])
        );
    end

endmodule

// File: tb/tb_multi_channel_tick_gen.sv
// Self-checking bench for multi_channel_tick_gen: directed scenarios plus a randomized
// run, all compared against a half-period-timeline reference model.
module tb_multi_channel_tick_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int DEF    = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] out_clk;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    multi_channel_tick_gen #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .out_clk   (out_clk),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Reference model: each channel remembers the edge at which its current half-period
    // began; the level flips once that half-period has lasted eff edges.
    bit [NUM_CH-1:0] m_out, m_tick, m_pv;
    int unsigned     m_half[NUM_CH];
    int unsigned     m_pend[NUM_CH];
    longint          m_seg[NUM_CH];
    longint          cyc = 0;

    task automatic model_update();
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            bit          bnd;
            bit          xfer;
            int unsigned eff;
            if (rst) begin
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_pv[i]   = 1'b0;
                m_half[i] = DEF;
                m_seg[i]  = cyc + 1;
            end else begin
                xfer = cfg_valid && (int'(cfg_ch) == i) && !m_pv[i];
                eff  = (m_half[i] == 0) ? 1 : m_half[i];
                bnd  = 1'b1;
                if (!ch_en[i] || sync) begin
                    m_out[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                    m_seg[i]  = cyc + 1;
                end else if (cyc - m_seg[i] + 1 == longint'(eff)) begin
                    m_tick[i] = !m_out[i];
                    m_out[i]  = !m_out[i];
                    m_seg[i]  = cyc + 1;
                end else begin
                    m_tick[i] = 1'b0;
                    bnd       = 1'b0;
                end
                if (m_pv[i] && bnd) begin
                    m_half[i] = m_pend[i];
                    m_pv[i]   = 1'b0;
                end else if (xfer) begin
                    m_pend[i] = cfg_half;
                    m_pv[i]   = 1'b1;
                end
            end
        end
    endtask

    function automatic bit m_ready();
        if (int'(cfg_ch) < NUM_CH) return !m_pv[cfg_ch];
        return 1'b1;
    endfunction

    // Inputs only change at the falling edge, so the model sees the same values the DUT
    // sampled at the rising edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
        repeat (2) cycle();
        checks++;
        if (out_clk !== 3'b000 || tick !== 3'b000 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values out_clk=%b tick=%b ready=%b exp 000 000 1",
                     out_clk, tick, cfg_ready);
        end
        rst = 1'b0; ch_en = 3'b001;
        for (int k = 1; k <= DEF; k++) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL reset_model t=%0t out=%b/%b tick=%b/%b rdy=%b/%b", $time,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
            checks++;
            if (tick[0] !== (k == DEF) || out_clk[0] !== (k == DEF)) begin
                errors++;
                $display("FAIL default_first_rise k=%0d out=%b tick=%b exp %b", k,
                         out_clk[0], tick[0], (k == DEF));
            end
        end
        // Asynchronous reset while ch0 is high.
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_clk !== 3'b000 || tick !== 3'b000) begin
            errors++;
            $display("FAIL async_reset out_clk=%b tick=%b exp 000 000", out_clk, tick);
        end
        cycle();
        checks++;
        if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
            errors++;
            $display("FAIL async_reset_model out=%b/%b tick=%b/%b", out_clk, m_out, tick, m_tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_period();
        int highs = 0;
        int ticks = 0;
        ch_en = 3'b000; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 3;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        ch_en = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL period_model t=%0t out=%b/%b tick=%b/%b rdy=%b/%b", $time,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
            checks++;
            if (out_clk[0] !== ((k % 6) >= 3) || tick[0] !== ((k % 6) == 3)) begin
                errors++;
                $display("FAIL period_shape k=%0d out=%b tick=%b exp %b %b", k, out_clk[0],
                         tick[0], ((k % 6) >= 3), ((k % 6) == 3));
            end
            if (out_clk[0] === 1'b1) highs++;
            if (tick[0] === 1'b1) ticks++;
        end
        checks++;
        if (highs != 6 || ticks != 2) begin
            errors++;
            $display("FAIL period_counts highs=%0d ticks=%0d exp 6 2", highs, ticks);
        end
    endtask

    task automatic test_glitch_free();
        bit [9:0] pat = 10'b1100110000;
        bit [4:0] rdy = 5'b10001;
        ch_en[1] = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 5;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        ch_en[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL glitch_model t=%0t out=%b/%b tick=%b/%b rdy=%b/%b", $time,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
            checks++;
            if (out_clk[1] !== pat[k]) begin
                errors++;
                $display("FAIL glitch_shape k=%0d out=%b exp %b", k, out_clk[1], pat[k]);
            end
            if (k <= 4) begin
                checks++;
                if (cfg_ready !== rdy[k]) begin
                    errors++;
                    $display("FAIL glitch_ready k=%0d ready=%b exp %b", k, cfg_ready, rdy[k]);
                end
            end
            if (k == 0) begin
                cfg_valid = 1'b1; cfg_half = 2;
            end else if (k == 1) begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_pressure();
        bit found = 1'b0;
        ch_en = 3'b111; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 7;
        cycle();
        checks++;
        if (out_clk !== m_out || tick !== m_tick || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_held out=%b/%b tick=%b/%b ready=%b exp 0", out_clk, m_out,
                     tick, m_tick, cfg_ready);
        end
        cfg_half = 9;
        cycle();
        checks++;
        if (out_clk !== m_out || tick !== m_tick || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_held out=%b/%b tick=%b/%b ready=%b exp 0", out_clk, m_out,
                     tick, m_tick, cfg_ready);
        end
        cfg_ch = 2'd0; cfg_half = 4;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ch_ready ready=%b exp 1", cfg_ready);
        end
        cycle();
        checks++;
        if (out_clk !== m_out || tick !== m_tick || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_other_ch_accepted out=%b/%b tick=%b/%b ready=%b exp 0", out_clk,
                     m_out, tick, m_tick, cfg_ready);
        end
        cfg_ch = 2'd2; cfg_half = 9;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL bp_wait_model t=%0t out=%b/%b tick=%b/%b rdy=%b/%b", $time,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
            if (cfg_ready === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_wait_timeout ready=%b exp 1 within 30 cycles", cfg_ready);
        end
        cycle();
        cfg_valid = 1'b0;
        checks++;
        if (out_clk !== m_out || tick !== m_tick || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accepted out=%b/%b tick=%b/%b ready=%b exp 0", out_clk,
                     m_out, tick, m_tick, cfg_ready);
        end
    endtask

    task automatic test_edge_values();
        ch_en = 3'b000; cfg_valid = 1'b0;
        repeat (2) cycle();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 0;
        cycle();
        cfg_ch = 2'd1; cfg_half = 1;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        ch_en = 3'b011;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL edge_model t=%0t out=%b/%b tick=%b/%b rdy=%b/%b", $time,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
            checks++;
            if (out_clk[1:0] !== {2{k % 2 == 0}} || tick[1:0] !== {2{k % 2 == 0}}) begin
                errors++;
                $display("FAIL edge_toggle k=%0d out=%b tick=%b exp %b", k, out_clk[1:0],
                         tick[1:0], {2{k % 2 == 0}});
            end
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 5;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL edge_bad_ch_ready ready=%b exp 1", cfg_ready);
        end
        repeat (4) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL edge_bad_ch_effect out=%b/%b tick=%b/%b ready=%b", out_clk,
                         m_out, tick, m_tick, cfg_ready);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_sync_enable();
        ch_en = 3'b000;
        repeat (2) cycle();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 4;
        cycle();
        cfg_ch = 2'd1;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        ch_en = 3'b001;
        repeat (2) cycle();
        ch_en = 3'b011;
        repeat (5) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL sync_model t=%0t out=%b/%b tick=%b/%b rdy=%b/%b", $time,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
            checks++;
            if (out_clk[0] !== out_clk[1] || tick[0] !== tick[1]) begin
                errors++;
                $display("FAIL sync_aligned k=%0d out=%b tick=%b exp equal bits", k,
                         out_clk[1:0], tick[1:0]);
            end
        end
        ch_en[0] = 1'b0;
        cycle();
        checks++;
        if (out_clk[0] !== 1'b0 || tick[0] !== 1'b0 || out_clk !== m_out) begin
            errors++;
            $display("FAIL disable_clears out=%b tick=%b exp 0 0", out_clk[0], tick[0]);
        end
        ch_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (out_clk[0] !== (k == 3) || out_clk !== m_out || tick !== m_tick) begin
                errors++;
                $display("FAIL reenable_rise k=%0d out=%b exp %b", k, out_clk[0], (k == 3));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) ch_en = ch_en ^ 3'($urandom_range(1, 7));
            sync      = ($urandom_range(0, 19) == 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_half  = $urandom_range(0, 6);
            cycle();
            checks++;
            if (out_clk !== m_out || tick !== m_tick || cfg_ready !== m_ready()) begin
                errors++;
                $display("FAIL random_model k=%0d out=%b/%b tick=%b/%b rdy=%b/%b", k,
                         out_clk, m_out, tick, m_tick, cfg_ready, m_ready());
            end
        end
        sync = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period();
        test_glitch_free();
        test_back_pressure();
        test_edge_values();
        test_sync_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_tick_gen.md
Name: multi_channel_tick_gen

Overview:
- NUM_CH independent programmable clock-enable generators for reel spin, blink and debounce timing.
- Each channel emits a 50%-duty divided clock (out_clk) and a one-cycle tick strobe on each out_clk rising edge. Logic downstream uses the tick as an enable rather than as a clock.
- Channels take a half-period count in input-clock cycles, so no runtime divider is needed.
- Reconfiguration goes through a valid/ready port. New values apply glitch-free at the next toggle boundary. A global sync realigns the phase of all channels.

Parameters:
- NUM_CH, 3: number of channels (1..16).
- CNT_W, 32: width of the half-period counter and config value.
- DEFAULT_HALF, 25_000_000: half-period loaded at reset (1 Hz at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle phase-realign pulse for all channels.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted for cfg_ch.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_half  in  CNT_W  new half-period in cycles.
- out_clk  out  NUM_CH  divided square wave per channel.
- tick  out  NUM_CH  one-cycle strobe, high in the first cycle out_clk is high.

Behaviour:
- Reset (async, any time, including mid-period): cnt=0, out_clk=0, tick=0, half_q=DEFAULT_HALF, pend_v=0 for every channel.
- Effective half: eff = (half_q==0) ? 1 : half_q. A value of 0 behaves as 1.
- Running channel (ch_en=1), each edge:
  - If cnt==eff-1: cnt<=0, out_clk<=~out_clk, tick<=~out_clk (tick pulses only on the 0->1 toggle).
  - Otherwise: cnt<=cnt+1, tick<=0.
- Output period is 2*eff cycles.
- First rise after enable: out_clk goes high on the eff-th edge at which ch_en is sampled high. Example: half=3, ch_en high from edge E0 -> out_clk rises at E2.
- Disabled channel (ch_en=0): cnt<=0, out_clk<=0, tick<=0. Any pending config is applied on the next edge.
- Config handshake:
  - cfg_ready = !pend_v[cfg_ch], combinational, no dependence on cfg_valid.
  - Transfer occurs when cfg_valid && cfg_ready; it writes pend_q[cfg_ch]=cfg_half and sets pend_v.
  - cfg_ch >= NUM_CH: cfg_ready=1, transfer is discarded.
- Apply rule: when pend_v is set and the channel is at a toggle edge, disabled, or sync is high, then half_q<=pend_q and pend_v<=0. The new half governs the very next half-period. A half-period already in progress is never shortened or stretched.
- Simultaneous transfer and apply on the same channel: not possible, since cfg_ready is low while pend_v is set. One transfer per channel per apply.
- sync=1: every enabled channel forces cnt<=0, out_clk<=0, tick<=0 and applies pending config. After sync, all enabled channels with equal half are edge-aligned.
- Priority per channel: rst > ch_en=0 > sync > terminal count > increment.
- Width: counter compare is on CNT_W bits unsigned. No wrap is possible because cnt < eff <= 2^CNT_W-1.
- All outputs except cfg_ready are registered. Latency from an accepted config to effect is at most one half-period plus one cycle.

Decomposition:
- Package tick_gen_pkg:
  - CH_IDX_W(n) function (min 1).
  - DEFAULT_HALF_50M and DEFAULT_HALF_1K constants.
  - Typedef struct ch_state_t {cnt, half_q, pend_q, pend_v, out_clk, tick}.
- Sub-module tick_gen_channel:
  - One channel: counter, toggle, pending register and apply logic.
  - Inputs: en, sync, wr, wr_half. Outputs: out_clk, tick, pend_v.
- Top: cfg decode, cfg_ready mux, generate loop over NUM_CH channels.

Test Plan:
- Reset values: assert rst mid-run with out_clk=1 -> out_clk=0, tick=0 immediately (async); after release, ch0 with default half runs and no tick occurs within the first DEFAULT_HALF-1 cycles.
- Period: ch0 cfg_half=3 with en high -> out_clk period 6, high 3 / low 3; tick exactly 1 cycle every 6 cycles, coincident with the first high cycle.
- Glitch-free update: ch1 half=5, write half=2 at cnt=1 -> current half-period still lasts 5 cycles, then 2/2 pattern; cfg_ready for ch1 low until the apply edge, then high.
- Back-pressure: two consecutive writes to ch2 -> second held (cfg_ready=0) until the first applies; third write to ch0 in the same window is accepted.
- Edge values: half=0 and half=1 -> out_clk toggles every cycle, tick every 2 cycles; cfg_ch=NUM_CH is accepted and has no effect.
- Sync and enable: ch0 half=4, ch1 half=4 started 2 cycles apart, pulse sync -> identical out_clk waveforms thereafter; drop ch_en -> out_clk=0, cnt=0 next edge; re-enable -> first rise after 4 edges.
